// File: rtl/axi_mem_pkg.sv
// rtl/axi_mem_pkg.sv - shared types and helpers for the AXI memory responder
// Purpose: FSM state enums, beat counter width and burst-length helper.
// Ports: none (package).
package axi_mem_pkg;

  typedef enum logic [1:0] {R_IDLE, R_WAIT, R_BURST} r_state_t;
  typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_t;

  localparam int BEAT_CNT_WIDTH = 4;

  // Number of beats in a burst of the given LEN field (1..16).
  function automatic logic [BEAT_CNT_WIDTH:0] beats(input logic [BEAT_CNT_WIDTH-1:0] len);
    return {1'b0, len} + (BEAT_CNT_WIDTH+1)'(1);
  endfunction

endpackage

// File: rtl/axi_mem_responder_if.sv
// rtl/axi_mem_responder_if.sv - AW/W/B/AR/R channel bundle for the memory responder
// Purpose: groups the five AXI3-subset channels.
// Ports: master modport drives requests (core side), slave modport drives responses (memory side).
interface axi_mem_responder_if #(
  parameter int ADDR_WIDTH = 26,
  parameter int DATA_WIDTH = 32
);
  logic                  AWVALID, AWREADY;
  logic [3:0]            AWID, AWLEN;
  logic [ADDR_WIDTH-1:0] AWADDR;
  logic                  WVALID, WREADY, WLAST;
  logic [3:0]            WID;
  logic [DATA_WIDTH-1:0] WDATA;
  logic                  BVALID, BREADY;
  logic [3:0]            BID;
  logic                  ARVALID, ARREADY;
  logic [3:0]            ARID, ARLEN;
  logic [ADDR_WIDTH-1:0] ARADDR;
  logic                  RVALID, RREADY, RLAST;
  logic [3:0]            RID;
  logic [DATA_WIDTH-1:0] RDATA;

  modport master (
    output AWVALID, AWID, AWLEN, AWADDR, WVALID, WLAST, WID, WDATA, BREADY,
           ARVALID, ARID, ARLEN, ARADDR, RREADY,
    input  AWREADY, WREADY, BVALID, BID, ARREADY, RVALID, RLAST, RID, RDATA
  );

  modport slave (
    input  AWVALID, AWID, AWLEN, AWADDR, WVALID, WLAST, WID, WDATA, BREADY,
           ARVALID, ARID, ARLEN, ARADDR, RREADY,
    output AWREADY, WREADY, BVALID, BID, ARREADY, RVALID, RLAST, RID, RDATA
  );
endinterface

// File: rtl/axi_mem_sram.sv
// rtl/axi_mem_sram.sv - 1W/1R synchronous word array
// Purpose: backing store, 2^DEPTH_WIDTH words, 1-cycle registered read.
// Ports: clk; we/waddr/wdata write port; re/raddr read request; rdata
//        holds its value when re is low. A same-cycle read of the word
//        being written returns the old contents.
module axi_mem_sram #(
  parameter int DATA_WIDTH  = 32,
  parameter int DEPTH_WIDTH = 14
) (
  input  logic                   clk,
  input  logic                   we,
  input  logic [DEPTH_WIDTH-1:0] waddr,
  input  logic [DATA_WIDTH-1:0]  wdata,
  input  logic                   re,
  input  logic [DEPTH_WIDTH-1:0] raddr,
  output logic [DATA_WIDTH-1:0]  rdata
);
  logic [DATA_WIDTH-1:0] mem [0:(1<<DEPTH_WIDTH)-1];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    if (re) rdata <= mem[raddr];
  end
endmodule

// File: rtl/axi_mem_responder.sv
// rtl/axi_mem_responder.sv - AXI3-subset memory slave with programmable read latency
// Purpose: one INCR burst per direction, word-addressed SRAM, independent
//          read and write FSMs sharing the array.
// Ports: clk, rst (sync, active high); bus (slave modport: AW/W/B/AR/R);
//        protocol_error (sticky WLAST/WID mismatch flag).
module axi_mem_responder #(
  parameter int ADDR_WIDTH   = 26,
  parameter int DATA_WIDTH   = 32,
  parameter int DEPTH_WIDTH  = 14,
  parameter int READ_LATENCY = 4
) (
  input  logic                clk,
  input  logic                rst,
  axi_mem_responder_if.slave  bus,
  output logic                protocol_error
);
  import axi_mem_pkg::*;

  localparam logic [DEPTH_WIDTH-1:0] IDX_ONE  = DEPTH_WIDTH'(1);
  localparam logic [3:0]             LAT_LOAD = 4'(READ_LATENCY - 1);

  r_state_t r_state, r_state_nxt;
  w_state_t w_state, w_state_nxt;

  logic [3:0]                r_id, w_id, lat_cnt;
  logic [BEAT_CNT_WIDTH-1:0] r_len, r_cnt, w_len, w_cnt;
  logic [DEPTH_WIDTH-1:0]    r_idx, w_idx;
  logic                      r_last, w_last, ar_hs, r_hs, aw_hs, err_set, err_q;
  logic                      sram_re, sram_we;
  logic [DEPTH_WIDTH-1:0]    sram_raddr;
  logic [DATA_WIDTH-1:0]     sram_q;

  // Only the word-index bits of the addresses matter; the rest alias.
  logic [ADDR_WIDTH-1:0] unused_addr;
  assign unused_addr = bus.AWADDR ^ bus.ARADDR;

  assign r_last = ({1'b0, r_cnt} + (BEAT_CNT_WIDTH+1)'(1)) == beats(r_len);
  assign w_last = ({1'b0, w_cnt} + (BEAT_CNT_WIDTH+1)'(1)) == beats(w_len);

  assign protocol_error = err_q & ~rst;

  axi_mem_sram #(.DATA_WIDTH(DATA_WIDTH), .DEPTH_WIDTH(DEPTH_WIDTH)) u_sram (
    .clk   (clk),
    .we    (sram_we),
    .waddr (w_idx),
    .wdata (bus.WDATA),
    .re    (sram_re),
    .raddr (sram_raddr),
    .rdata (sram_q)
  );

  // Read FSM. sram_q is only reloaded when a beat is consumed (or while
  // fetching beat 0), so RDATA stays frozen through RREADY stalls, and the
  // next word is fetched in the handshake cycle for 1 beat/cycle throughput.
  always_comb begin
    r_state_nxt = r_state;
    bus.ARREADY = 1'b0;
    bus.RVALID  = 1'b0;
    bus.RLAST   = 1'b0;
    bus.RID     = '0;
    bus.RDATA   = '0;
    sram_re     = 1'b0;
    sram_raddr  = r_idx + IDX_ONE;
    ar_hs       = 1'b0;
    r_hs        = 1'b0;
    if (!rst) begin
      case (r_state)
        R_IDLE: begin
          bus.ARREADY = 1'b1;
          // Fetch beat 0 straight from ARADDR so a latency of 1 is reachable.
          sram_raddr  = bus.ARADDR[DEPTH_WIDTH+1:2];
          if (bus.ARVALID) begin
            ar_hs       = 1'b1;
            sram_re     = 1'b1;
            r_state_nxt = (READ_LATENCY == 1) ? R_BURST : R_WAIT;
          end
        end
        R_WAIT: begin
          // Re-read beat 0 every wait cycle; the last read picks up any write
          // that landed during the wait.
          sram_raddr = r_idx;
          sram_re    = 1'b1;
          if (lat_cnt == 4'd1) r_state_nxt = R_BURST;
        end
        R_BURST: begin
          bus.RVALID = 1'b1;
          bus.RLAST  = r_last;
          bus.RID    = r_id;
          bus.RDATA  = sram_q;
          if (bus.RREADY) begin
            r_hs = 1'b1;
            if (r_last) r_state_nxt = R_IDLE;
            else        sram_re     = 1'b1;
          end
        end
        default: r_state_nxt = R_IDLE;
      endcase
    end
  end

  // Write FSM.
  always_comb begin
    w_state_nxt = w_state;
    bus.AWREADY = 1'b0;
    bus.WREADY  = 1'b0;
    bus.BVALID  = 1'b0;
    bus.BID     = '0;
    sram_we     = 1'b0;
    aw_hs       = 1'b0;
    err_set     = 1'b0;
    if (!rst) begin
      case (w_state)
        W_IDLE: begin
          bus.AWREADY = 1'b1;
          if (bus.AWVALID) begin
            aw_hs       = 1'b1;
            w_state_nxt = W_DATA;
          end
        end
        W_DATA: begin
          bus.WREADY = 1'b1;
          if (bus.WVALID) begin
            sram_we = 1'b1;
            err_set = (bus.WLAST != w_last) || (bus.WID != w_id);
            if (w_last) w_state_nxt = W_RESP;
          end
        end
        W_RESP: begin
          bus.BVALID = 1'b1;
          bus.BID    = w_id;
          if (bus.BREADY) w_state_nxt = W_IDLE;
        end
        default: w_state_nxt = W_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= R_IDLE;
      w_state <= W_IDLE;
      err_q   <= 1'b0;
      r_id    <= '0;
      r_len   <= '0;
      r_cnt   <= '0;
      r_idx   <= '0;
      lat_cnt <= '0;
      w_id    <= '0;
      w_len   <= '0;
      w_cnt   <= '0;
      w_idx   <= '0;
    end else begin
      r_state <= r_state_nxt;
      w_state <= w_state_nxt;
      if (err_set) err_q <= 1'b1;
      if (ar_hs) begin
        r_id    <= bus.ARID;
        r_len   <= bus.ARLEN;
        r_idx   <= bus.ARADDR[DEPTH_WIDTH+1:2];
        r_cnt   <= '0;
        lat_cnt <= LAT_LOAD;
      end
      if (r_state == R_WAIT) lat_cnt <= lat_cnt - 4'd1;
      if (r_hs) begin
        r_idx <= r_idx + IDX_ONE;
        r_cnt <= r_cnt + BEAT_CNT_WIDTH'(1);
      end
      if (aw_hs) begin
        w_id  <= bus.AWID;
        w_len <= bus.AWLEN;
        w_idx <= bus.AWADDR[DEPTH_WIDTH+1:2];
        w_cnt <= '0;
      end
      if (sram_we) begin
        w_idx <= w_idx + IDX_ONE;
        w_cnt <= w_cnt + BEAT_CNT_WIDTH'(1);
      end
    end
  end
endmodule

// File: tb/tb_axi_mem_responder.sv
// tb/tb_axi_mem_responder.sv - self-checking bench for axi_mem_responder
module tb_axi_mem_responder;
  localparam int AW = 26, DW = 32, DEPTHW = 14, LAT = 4;
  localparam int NWORDS = 1 << DEPTHW;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic protocol_error;

  axi_mem_responder_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus();

  axi_mem_responder #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .DEPTH_WIDTH(DEPTHW), .READ_LATENCY(LAT)
  ) dut (
    .clk(clk), .rst(rst), .bus(bus), .protocol_error(protocol_error)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  logic [31:0] model [int];
  logic [31:0] wbuf [16];
  int          early_last = -1;
  logic [3:0]  wid_xor = 4'd0;
  int          w_beats, w_hs_cyc, w_timeout;
  logic [3:0]  bid_got;

  logic [31:0] rbuf [16];
  logic [3:0]  rid_buf [16];
  logic        rlast_buf [16];
  int          r_beats, r_lat, r_hs_cyc, r_end_cyc, r_timeout, stall_err;
  logic        ar_at_last;
  int          rr_mode = 0;
  logic        rr_pat [7] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};

  function automatic int widx(input logic [25:0] a);
    return (int'(a) / 4) % NWORDS;
  endfunction

  task automatic do_write(input logic [25:0] addr, input int len, input logic [3:0] id);
    int t;
    w_timeout = 0;
    w_beats   = 0;
    @(posedge clk); #1;
    bus.AWVALID = 1'b1; bus.AWADDR = addr; bus.AWLEN = 4'(len); bus.AWID = id;
    for (t = 0; t < 50; t++) begin @(negedge clk); if (bus.AWREADY) break; end
    if (t == 50) w_timeout = 1;
    w_hs_cyc = cyc;
    @(posedge clk); #1;
    bus.AWVALID = 1'b0;
    for (int i = 0; i <= len; i++) begin
      bus.WVALID = 1'b1; bus.WDATA = wbuf[i]; bus.WID = id ^ wid_xor;
      bus.WLAST  = (early_last >= 0) ? (i == early_last) : (i == len);
      for (t = 0; t < 50; t++) begin @(negedge clk); if (bus.WREADY) break; end
      if (t == 50) w_timeout = 1; else w_beats++;
      model[(widx(addr) + i) % NWORDS] = wbuf[i];
      @(posedge clk); #1;
    end
    bus.WVALID = 1'b0; bus.WLAST = 1'b0;
    for (t = 0; t < 50; t++) begin @(negedge clk); if (bus.BVALID) break; end
    if (t == 50) w_timeout = 1;
    bid_got = bus.BID;
    @(posedge clk); #1;
  endtask

  task automatic do_read(input logic [25:0] addr, input int len, input logic [3:0] id);
    int t, k;
    logic hold_v;
    logic [31:0] hold_d;
    r_timeout = 0; r_beats = 0; r_lat = -1; stall_err = 0; hold_v = 1'b0; k = 0;
    ar_at_last = 1'b1; r_end_cyc = -1;
    @(posedge clk); #1;
    bus.ARVALID = 1'b1; bus.ARADDR = addr; bus.ARLEN = 4'(len); bus.ARID = id; bus.RREADY = 1'b0;
    for (t = 0; t < 50; t++) begin @(negedge clk); if (bus.ARREADY) break; end
    if (t == 50) r_timeout = 1;
    r_hs_cyc = cyc;
    t = 0;
    while (r_beats <= len && t < 300) begin
      @(posedge clk); #1;
      bus.ARVALID = 1'b0;
      if (bus.RVALID) begin
        case (rr_mode)
          0:       bus.RREADY = 1'b1;
          1:       bus.RREADY = rr_pat[k % 7];
          default: bus.RREADY = 1'($urandom_range(0, 1));
        endcase
        k++;
      end else begin
        bus.RREADY = 1'b0;
      end
      @(negedge clk);
      if (hold_v && (!bus.RVALID || bus.RDATA !== hold_d)) stall_err++;
      hold_v = 1'b0;
      if (bus.RVALID) begin
        if (r_lat < 0) r_lat = cyc - r_hs_cyc;
        if (bus.RREADY) begin
          rbuf[r_beats] = bus.RDATA; rid_buf[r_beats] = bus.RID; rlast_buf[r_beats] = bus.RLAST;
          r_beats++;
          if (r_beats == len + 1) begin ar_at_last = bus.ARREADY; r_end_cyc = cyc; end
        end else begin
          hold_v = 1'b1; hold_d = bus.RDATA;
        end
      end
      t++;
    end
    if (t >= 300) r_timeout = 1;
    @(posedge clk); #1;
    bus.RREADY = 1'b0;
  endtask

  task automatic test_reset;
    bus.AWVALID = 0; bus.AWID = 0; bus.AWLEN = 0; bus.AWADDR = 0;
    bus.WVALID = 0; bus.WLAST = 0; bus.WID = 0; bus.WDATA = 0; bus.BREADY = 1;
    bus.ARVALID = 0; bus.ARID = 0; bus.ARLEN = 0; bus.ARADDR = 0; bus.RREADY = 0;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++;
    if ({bus.AWREADY, bus.WREADY, bus.BVALID, bus.ARREADY, bus.RVALID, bus.RLAST, protocol_error,
         bus.BID, bus.RID, bus.RDATA} !== '0) begin
      errors++; $display("FAIL reset_outputs got aw%b w%b b%b ar%b r%b err%b want all 0",
        bus.AWREADY, bus.WREADY, bus.BVALID, bus.ARREADY, bus.RVALID, protocol_error);
    end
    @(posedge clk); #1; rst = 1'b0;
    @(negedge clk);
    checks++;
    if ({bus.AWREADY, bus.ARREADY, bus.WREADY} !== 3'b110) begin
      errors++; $display("FAIL post_reset_ready got %b want 110", {bus.AWREADY, bus.ARREADY, bus.WREADY});
    end
  endtask

  task automatic test_single;
    wbuf[0] = 32'hDEADBEEF;
    do_write(26'h100, 0, 4'd3);
    checks++;
    if (w_timeout != 0 || bid_got !== 4'd3) begin
      errors++; $display("FAIL single_bid got %0h (timeout %0d) want 3", bid_got, w_timeout);
    end
    rr_mode = 0;
    do_read(26'h100, 0, 4'd5);
    checks++;
    if (r_timeout != 0 || r_lat != LAT) begin
      errors++; $display("FAIL single_latency got %0d want %0d", r_lat, LAT);
    end
    checks++;
    if (rbuf[0] !== 32'hDEADBEEF || rid_buf[0] !== 4'd5 || rlast_buf[0] !== 1'b1) begin
      errors++; $display("FAIL single_rdata got %h id %0h last %b want deadbeef 5 1", rbuf[0], rid_buf[0], rlast_buf[0]);
    end
  endtask

  task automatic test_burst;
    for (int i = 0; i < 16; i++) wbuf[i] = i;
    do_write(26'h2000, 15, 4'd1);
    rr_mode = 0;
    do_read(26'h2000, 15, 4'd2);
    checks++;
    if (r_beats != 16 || r_end_cyc - r_hs_cyc != LAT + 15) begin
      errors++; $display("FAIL burst_timing got beats %0d span %0d want 16 %0d", r_beats, r_end_cyc - r_hs_cyc, LAT + 15);
    end
    for (int i = 0; i < 16; i++) begin
      checks++;
      if (rbuf[i] !== 32'(i) || rlast_buf[i] !== (i == 15)) begin
        errors++; $display("FAIL burst_beat%0d got %h last %b want %h last %b", i, rbuf[i], rlast_buf[i], i, i == 15);
      end
    end
    checks++;
    if (ar_at_last !== 1'b0) begin
      errors++; $display("FAIL arready_on_last got %b want 0", ar_at_last);
    end
    @(negedge clk);
    checks++;
    if (bus.ARREADY !== 1'b1) begin
      errors++; $display("FAIL arready_after_burst got %b want 1", bus.ARREADY);
    end
  endtask

  task automatic test_backpressure;
    for (int i = 0; i < 4; i++) wbuf[i] = $urandom;
    do_write(26'h3000, 3, 4'd6);
    rr_mode = 1;
    do_read(26'h3000, 3, 4'd6);
    checks++;
    if (r_beats != 4 || stall_err != 0 || r_timeout != 0) begin
      errors++; $display("FAIL backpressure got beats %0d stall_err %0d want 4 0", r_beats, stall_err);
    end
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (rbuf[i] !== wbuf[i]) begin
        errors++; $display("FAIL bp_beat%0d got %h want %h", i, rbuf[i], wbuf[i]);
      end
    end
  endtask

  task automatic test_wrap;
    int words [4] = '{16382, 16383, 0, 1};
    for (int i = 0; i < 4; i++) wbuf[i] = $urandom;
    do_write(26'h0FFF8, 3, 4'd2);
    rr_mode = 0;
    for (int i = 0; i < 4; i++) begin
      // Upper address bit set to exercise aliasing.
      do_read(26'(words[i] * 4 + (1 << 20)), 0, 4'd4);
      checks++;
      if (rbuf[0] !== wbuf[i]) begin
        errors++; $display("FAIL wrap_word%0d got %h want %h", words[i], rbuf[0], wbuf[i]);
      end
    end
  endtask

  task automatic test_random;
    logic [25:0] addr;
    logic [3:0]  id;
    int len, base;
    for (int n = 0; n < 10; n++) begin
      len  = $urandom_range(0, 15);
      addr = 26'($urandom);
      id   = 4'($urandom);
      for (int i = 0; i <= len; i++) wbuf[i] = $urandom;
      do_write(addr, len, id);
      checks++;
      if (w_timeout != 0 || bid_got !== id) begin
        errors++; $display("FAIL rand%0d_bid got %0h want %0h", n, bid_got, id);
      end
      rr_mode = 2;
      do_read(addr ^ 26'h2000000, len, ~id);
      base = widx(addr);
      for (int i = 0; i <= len; i++) begin
        checks++;
        if (rbuf[i] !== model[(base + i) % NWORDS] || rid_buf[i] !== ~id || rlast_buf[i] !== (i == len)) begin
          errors++; $display("FAIL rand%0d_beat%0d got %h want %h", n, i, rbuf[i], model[(base + i) % NWORDS]);
        end
      end
      checks++;
      if (stall_err != 0 || r_beats != len + 1) begin
        errors++; $display("FAIL rand%0d_stream got beats %0d stall_err %0d want %0d 0", n, r_beats, stall_err, len + 1);
      end
    end
    checks++;
    if (protocol_error !== 1'b0) begin
      errors++; $display("FAIL no_false_error got %b want 0", protocol_error);
    end
  endtask

  task automatic test_protocol_error;
    for (int i = 0; i < 4; i++) wbuf[i] = $urandom;
    early_last = 1;
    do_write(26'h4000, 3, 4'd7);
    early_last = -1;
    checks++;
    if (w_beats != 4 || bid_got !== 4'd7 || w_timeout != 0 || protocol_error !== 1'b1) begin
      errors++; $display("FAIL wlast_error got beats %0d bid %0h err %b want 4 7 1", w_beats, bid_got, protocol_error);
    end
    rr_mode = 0;
    do_read(26'h4000, 3, 4'd1);
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (rbuf[i] !== wbuf[i]) begin
        errors++; $display("FAIL perr_beat%0d got %h want %h", i, rbuf[i], wbuf[i]);
      end
    end
    @(posedge clk); #1; rst = 1'b1;
    @(posedge clk); #1; rst = 1'b0;
    @(negedge clk);
    checks++;
    if (protocol_error !== 1'b0) begin
      errors++; $display("FAIL error_cleared got %b want 0", protocol_error);
    end
    wbuf[0] = $urandom;
    wid_xor = 4'd1;
    do_write(26'h4100, 0, 4'd8);
    wid_xor = 4'd0;
    checks++;
    if (protocol_error !== 1'b1) begin
      errors++; $display("FAIL wid_error got %b want 1", protocol_error);
    end
    @(posedge clk); #1; rst = 1'b1;
    @(posedge clk); #1; rst = 1'b0;
  endtask

  task automatic test_reset_mid_burst_concurrency;
    int t, n;
    logic [31:0] w0, w1;
    @(posedge clk); #1;
    bus.ARVALID = 1'b1; bus.ARADDR = 26'h2000; bus.ARLEN = 4'd7; bus.ARID = 4'd9;
    for (t = 0; t < 50; t++) begin @(negedge clk); if (bus.ARREADY) break; end
    @(posedge clk); #1;
    bus.ARVALID = 1'b0; bus.RREADY = 1'b1;
    n = 0;
    for (t = 0; t < 50 && n < 2; t++) begin
      @(negedge clk);
      if (bus.RVALID) n++;
      if (n < 2) begin @(posedge clk); #1; end
    end
    checks++;
    if (n != 2) begin
      errors++; $display("FAIL midburst_start got %0d beats want 2", n);
    end
    @(posedge clk); #1; rst = 1'b1;
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      checks++;
      if ({bus.AWREADY, bus.WREADY, bus.BVALID, bus.ARREADY, bus.RVALID, bus.RLAST, protocol_error,
           bus.BID, bus.RID, bus.RDATA} !== '0) begin
        errors++; $display("FAIL midburst_reset_outputs%0d got rvalid %b rdata %h want 0", c, bus.RVALID, bus.RDATA);
      end
      @(posedge clk); #1;
    end
    rst = 1'b0; bus.RREADY = 1'b0;
    @(negedge clk);
    checks++;
    if ({bus.ARREADY, bus.AWREADY, bus.RVALID} !== 3'b110) begin
      errors++; $display("FAIL after_abort got %b want 110", {bus.ARREADY, bus.AWREADY, bus.RVALID});
    end
    w0 = $urandom; w1 = $urandom;
    wbuf[0] = w0; wbuf[1] = w1;
    rr_mode = 0;
    fork
      do_write(26'h5000, 1, 4'hA);
      do_read(26'h2000, 7, 4'hB);
    join
    checks++;
    if (w_hs_cyc != r_hs_cyc || bid_got !== 4'hA || r_beats != 8 || r_lat != LAT) begin
      errors++; $display("FAIL concurrent got aw@%0d ar@%0d bid %0h beats %0d lat %0d want same A 8 %0d",
        w_hs_cyc, r_hs_cyc, bid_got, r_beats, r_lat, LAT);
    end
    for (int i = 0; i < 8; i++) begin
      checks++;
      if (rbuf[i] !== 32'(i) || rid_buf[i] !== 4'hB) begin
        errors++; $display("FAIL preserved_beat%0d got %h want %h", i, rbuf[i], i);
      end
    end
    do_read(26'h5000, 1, 4'h3);
    checks++;
    if (rbuf[0] !== w0 || rbuf[1] !== w1) begin
      errors++; $display("FAIL concurrent_write got %h %h want %h %h", rbuf[0], rbuf[1], w0, w1);
    end
  endtask

  initial begin
    test_reset;
    test_single;
    test_burst;
    test_backpressure;
    test_wrap;
    test_random;
    test_protocol_error;
    test_reset_mid_burst_concurrency;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog simulation did not finish at cycle %0d", cyc);
    $fatal(1);
  end
endmodule

// File: doc/axi_mem_responder.md
Name: axi_mem_responder

Overview:
AXI3-subset slave (responder) backing memory for the core's memory arbiter. It sits on the far side of the AW/W/B and AR/R channels that the core drives, and serves as the simulation and FPGA stand-in for DRAM. It accepts one incrementing burst per direction, stores data in a word-addressed synchronous SRAM, and returns read bursts after a programmable latency. The read and write paths are independent FSMs that share one array.

Parameters:
ADDR_WIDTH, 26, byte-address width; matches `ADDR_WIDTH.
DATA_WIDTH, 32, beat and word width; matches `DATA_WIDTH.
DEPTH_WIDTH, 14, log2 of array depth in words (default 16K words).
READ_LATENCY, 4, cycles from AR handshake to first RVALID; legal range 1..15.

Ports:
clk  in  1  clock; all logic on posedge.
rst  in  1  synchronous, active-high reset.
AWVALID in 1; AWREADY out 1; AWID in 4; AWLEN in 4; AWADDR in ADDR_WIDTH  write-address channel.
WVALID in 1; WREADY out 1; WLAST in 1; WID in 4; WDATA in DATA_WIDTH  write-data channel.
BVALID out 1; BREADY in 1; BID out 4  write-response channel.
ARVALID in 1; ARREADY out 1; ARID in 4; ARLEN in 4; ARADDR in ADDR_WIDTH  read-address channel.
RVALID out 1; RREADY in 1; RLAST out 1; RID out 4; RDATA out DATA_WIDTH  read-data channel.
protocol_error  out  1  sticky flag; cleared only by rst.

Behaviour:
- Reset: every output is 0 during rst; both FSMs go to IDLE. Array contents are not cleared. Asserting rst mid-burst aborts the burst with no B or R completion.
- Word index = ADDR[DEPTH_WIDTH+1:2]; ADDR[1:0] is ignored. Upper address bits above the index alias. The beat count is LEN+1 (1..16). Beat address increments by 1 word and wraps modulo 2^DEPTH_WIDTH.
- Read FSM states: R_IDLE, R_WAIT, R_BURST.
  - R_IDLE: ARREADY=1. On ARVALID, latch ARID, ARLEN and the start index, load the latency counter with READ_LATENCY-1, then go to R_WAIT.
  - R_WAIT: ARREADY=0. Decrement the counter each cycle and issue the SRAM read for beat 0. Go to R_BURST so that RVALID rises exactly READ_LATENCY cycles after the AR handshake cycle.
  - R_BURST: RVALID=1 and RID=latched ID. RDATA is stable while RVALID && !RREADY. On each handshake, advance the index and beat count. The next beat may be presented the very next cycle (back-to-back, 1 beat/cycle sustained), which requires prefetching the next word.
  - RLAST=1 only on beat LEN. The handshake on the last beat returns the FSM to R_IDLE. ARREADY rises the following cycle, never in the same cycle.
- Write FSM states: W_IDLE, W_DATA, W_RESP.
  - W_IDLE: AWREADY=1, WREADY=0. On AWVALID, latch AWID, AWLEN and the index, then go to W_DATA.
  - W_DATA: WREADY=1. Each WVALID writes WDATA to the current index in that cycle and increments the index and beat count. After beat LEN is written, go to W_RESP.
  - WLAST disagreeing with the beat count (set early, or missing on beat LEN) sets protocol_error. The beat count still governs burst length. A WID differing from the latched AWID also sets protocol_error.
  - W_RESP: BVALID=1 and BID=latched AWID. Hold until BREADY, then go to W_IDLE.
- Simultaneous events:
  - A read and a write to the same word in the same cycle: the read returns the old data.
  - A write completes to the array before any later-issued SRAM read observes it, so no stale data is returned after the write cycle.
  - AW and AR may handshake in the same cycle. Both FSMs proceed independently.
- W beats arriving before the AW handshake are not accepted (WREADY=0 in W_IDLE).

Decomposition:
- Shared package axi_mem_pkg:
  - typedef enum r_state_t {R_IDLE, R_WAIT, R_BURST}.
  - typedef enum w_state_t {W_IDLE, W_DATA, W_RESP}.
  - localparam BEAT_CNT_WIDTH = 4.
  - Burst-length helper function beats(len) = len + 1.
- Sub-module axi_mem_sram: 1 write port and 1 read port, synchronous 1-cycle read, read-before-write on collision. Depth is 2^DEPTH_WIDTH words.

Test Plan:
1. Single write then single read. Stimulus: AW(addr 0x100, len 0, id 3) with W 0xDEADBEEF and WLAST; then AR(0x100, len 0, id 5) with RREADY held high. Response: BVALID with BID=3; RVALID exactly 4 cycles after the AR handshake, RDATA=0xDEADBEEF, RID=5, RLAST=1.
2. Burst write and read. Stimulus: 16-beat write at 0x2000 with data 0..15, then a 16-beat read. Response: 16 consecutive RVALID beats, data 0..15, RLAST only on beat 15.
3. RREADY backpressure. Stimulus: 4-beat read with RREADY toggling 1,0,0,1,1,0,1. Response: RDATA stable while stalled; no beat skipped or duplicated.
4. Address wrap. Stimulus: 4-beat write at word 2^14-2. Response: beats land at words 16382, 16383, 0, 1, confirmed by single-beat reads of each.
5. Protocol error. Stimulus: AWLEN=3 with WLAST asserted on beat 1. Response: protocol_error=1, 4 beats still accepted, BVALID issued; rst clears the flag.
6. Reset mid-burst plus concurrency. Stimulus: rst asserted during beat 2 of an 8-beat read, then AW and AR issued in the same cycle. Response: all outputs 0 during reset; after reset ARREADY=AWREADY=1, both transactions complete, and previously written data is preserved.
